alu_seq: RTL and testbench

//  Parametrised, handshaked ALU for the datapath. Accepts one operation per transaction

---
 rtl/alu_seq.sv | 254 +++++++++++++++++++++++++
 tb/tb_alu_seq.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq -- handshaked multi-function ALU with an iterative restoring divider.
//
// Takes one operation per transaction on a valid/ready input channel and presents
// the result and flags on a valid/ready output channel. Logic, add/sub and (by
// default) multiply finish in one cycle. Divide runs one restoring step per cycle
// for WIDTH cycles. A zero divisor short-cuts to a one-cycle all-ones result.
//
// Optional build macro:
//   ALU_ITER_MUL_EN  op 2 becomes an iterative shift-add multiplier (WIDTH cycles).
//                    rem then carries the high half of the product.
//                    When undefined, op 2 is single-cycle and rem = 0.
//
// Parameters:
//   WIDTH        operand/result width in bits (>= 4)
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   in_valid     operand/opcode valid
//   in_ready     block can accept a transaction (high only while idle)
//   a, b         operands
//   sel          opcode:
//                  0 a+b    1 a-b     2 a*b     3 a/b
//                  4 a&b    5 a|b     6 ~(a&b)  7 ~(a|b)
//                  8 ~a     9 ~b      A b-a     B b/a
//                  C ~a&~b  D ~a|~b   E a&~b    F ~a&b
//   out_valid    result/flags valid; held until out_ready
//   out_ready    consumer accepts the result
//   result       primary result
//   rem          division remainder (or high product half), else 0
//   cout         carry (op 0) or borrow (ops 1, A), else 0
//   zero         result == 0
//   div_by_zero  divide op saw a zero divisor
module alu_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] rem,
    output logic             cout,
    output logic             zero,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [WIDTH-1:0] hi;
        logic [WIDTH-1:0] lo;
    } pair_t;

    // One restoring-division step. hi holds the partial remainder, q shifts the
    // dividend out of its top and collects quotient bits in at the bottom.
    // The shifted remainder can reach WIDTH+1 bits; when its top bit is set it
    // is certainly >= d and the WIDTH-bit difference is still exact.
    function automatic pair_t div_step(input logic [WIDTH-1:0] r,
                                       input logic [WIDTH-1:0] q,
                                       input logic [WIDTH-1:0] d);
        logic [WIDTH:0]   sh;
        logic [WIDTH-1:0] diff;
        pair_t            o;
        sh   = {r, q[WIDTH-1]};
        diff = sh[WIDTH-1:0] - d;
        o.lo = {q[WIDTH-2:0], 1'b0};
        o.hi = sh[WIDTH-1:0];
        if (sh[WIDTH] || (sh[WIDTH-1:0] >= d)) begin
            o.hi    = diff;
            o.lo[0] = 1'b1;
        end
        return o;
    endfunction

`ifdef ALU_ITER_MUL_EN
    // One shift-add multiply step: conditionally add the multiplicand into the
    // high half, then shift the whole {carry, hi, lo} product right by one.
    function automatic pair_t mul_step(input logic [WIDTH-1:0] h,
                                       input logic [WIDTH-1:0] l,
                                       input logic [WIDTH-1:0] m);
        logic [WIDTH:0] s;
        pair_t          o;
        s    = l[0] ? ({1'b0, h} + {1'b0, m}) : {1'b0, h};
        o.hi = s[WIDTH:1];
        o.lo = {s[0], l[WIDTH-1:1]};
        return o;
    endfunction
`endif

    state_t           state;
    logic [CNT_W-1:0] iter_cnt;
    logic [WIDTH-1:0] work_hi;
    logic [WIDTH-1:0] work_lo;
    logic [WIDTH-1:0] opnd;
`ifdef ALU_ITER_MUL_EN
    logic             is_mul;
`endif

    logic             accept;
    logic             is_div_c;
    logic [WIDTH-1:0] dividend_c;
    logic [WIDTH-1:0] divisor_c;
    logic [WIDTH:0]   sum_c;
    logic [WIDTH-1:0] res_c;
    logic             cout_c;
    pair_t            step_c;

    assign accept = in_valid & in_ready;

    // Single-cycle datapath and divide operand steering, decoded from the live inputs.
    always_comb begin
        is_div_c   = (sel == 4'h3) || (sel == 4'hB);
        dividend_c = (sel == 4'h3) ? a : b;
        divisor_c  = (sel == 4'h3) ? b : a;
        sum_c      = {1'b0, a} + {1'b0, b};
        res_c      = '0;
        cout_c     = 1'b0;
        case (sel)
            4'h0: begin
                res_c  = sum_c[WIDTH-1:0];
                cout_c = sum_c[WIDTH];
            end
            4'h1: begin
                res_c  = a - b;
                cout_c = (a < b);
            end
            4'h2: res_c = a * b;
            4'h4: res_c = a & b;
            4'h5: res_c = a | b;
            4'h6: res_c = ~(a & b);
            4'h7: res_c = ~(a | b);
            4'h8: res_c = ~a;
            4'h9: res_c = ~b;
            4'hA: begin
                res_c  = b - a;
                cout_c = (b < a);
            end
            4'hC: res_c = ~a & ~b;
            4'hD: res_c = ~a | ~b;
            4'hE: res_c = a & ~b;
            4'hF: res_c = ~a & b;
            default: res_c = '0;
        endcase
    end

    always_comb begin
`ifdef ALU_ITER_MUL_EN
        step_c = is_mul ? mul_step(work_hi, work_lo, opnd)
                        : div_step(work_hi, work_lo, opnd);
`else
        step_c = div_step(work_hi, work_lo, opnd);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            iter_cnt    <= '0;
            result      <= '0;
            rem         <= '0;
            cout        <= 1'b0;
            zero        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        in_ready <= 1'b0;
                        if (is_div_c && (divisor_c == '0)) begin
                            result      <= '1;
                            rem         <= dividend_c;
                            cout        <= 1'b0;
                            zero        <= 1'b0;
                            div_by_zero <= 1'b1;
                            out_valid   <= 1'b1;
                            state       <= DONE;
                        end else if (is_div_c) begin
                            work_hi  <= '0;
                            work_lo  <= dividend_c;
                            opnd     <= divisor_c;
                            iter_cnt <= CNT_LAST;
`ifdef ALU_ITER_MUL_EN
                            is_mul   <= 1'b0;
`endif
                            state    <= BUSY;
`ifdef ALU_ITER_MUL_EN
                        end else if (sel == 4'h2) begin
                            work_hi  <= '0;
                            work_lo  <= b;
                            opnd     <= a;
                            iter_cnt <= CNT_LAST;
                            is_mul   <= 1'b1;
                            state    <= BUSY;
`endif
                        end else begin
                            result      <= res_c;
                            rem         <= '0;
                            cout        <= cout_c;
                            zero        <= (res_c == '0);
                            div_by_zero <= 1'b0;
                            out_valid   <= 1'b1;
                            state       <= DONE;
                        end
                    end
                end
                BUSY: begin
                    work_hi <= step_c.hi;
                    work_lo <= step_c.lo;
                    if (iter_cnt == '0) begin
                        result      <= step_c.lo;
                        rem         <= step_c.hi;
                        cout        <= 1'b0;
                        zero        <= (step_c.lo == '0);
                        div_by_zero <= 1'b0;
                        out_valid   <= 1'b1;
                        state       <= DONE;
                    end else begin
                        iter_cnt <= iter_cnt - 1'b1;
                    end
                end
                DONE: begin
                    // Outputs hold until the consumer takes them; a new op can be
                    // accepted from the following cycle.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq -- directed bench for alu_seq at WIDTH=16.
// A table of operations with hand-computed results and latencies, followed by
// hand-written sequences for reset, output back-pressure and reset mid-divide.
module tb_alu_seq;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   sel;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic [W-1:0] rem;
    logic         cout;
    logic         zero;
    logic         div_by_zero;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .sel         (sel),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .rem         (rem),
        .cout        (cout),
        .zero        (zero),
        .div_by_zero (div_by_zero)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [3:0]   sel;
        logic [W-1:0] res;
        logic [W-1:0] rm;
        logic         c;
        logic         z;
        logic         dz;
        int           lat;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic add(input logic [W-1:0] va, input logic [W-1:0] vb, input logic [3:0] vs,
                       input logic [W-1:0] vr, input logic [W-1:0] vm,
                       input logic vc, input logic vz, input logic vdz, input int vl);
        vec_t v;
        v.a = va; v.b = vb; v.sel = vs; v.res = vr; v.rm = vm;
        v.c = vc; v.z = vz; v.dz = vdz; v.lat = vl;
        vecs.push_back(v);
    endtask

    // Issue one op, measure cycles from the accept edge to out_valid, check the
    // outputs, then complete the output handshake.
    task automatic do_op(input vec_t v, input int idx);
        int lat;
        @(negedge clk);
        chk($sformatf("v%0d_in_ready_idle", idx), in_ready, 1);
        a = v.a; b = v.b; sel = v.sel; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        lat = 1;
        while (!out_valid && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        chk($sformatf("v%0d_latency", idx), lat, v.lat);
        chk($sformatf("v%0d_result", idx), result, v.res);
        chk($sformatf("v%0d_rem", idx), rem, v.rm);
        chk($sformatf("v%0d_cout", idx), cout, v.c);
        chk($sformatf("v%0d_zero", idx), zero, v.z);
        chk($sformatf("v%0d_dbz", idx), div_by_zero, v.dz);
        chk($sformatf("v%0d_in_ready_busy", idx), in_ready, 0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk($sformatf("v%0d_out_valid_drop", idx), out_valid, 0);
        chk($sformatf("v%0d_in_ready_back", idx), in_ready, 1);
    endtask

    initial begin
        bit seen;

        //   a        b        sel   result   rem      c  z  dz lat
        add(16'hFFFF, 16'h0001, 4'h0, 16'h0000, 16'h0000, 1, 1, 0, 1);
        add(16'h0003, 16'h0005, 4'h1, 16'hFFFE, 16'h0000, 1, 0, 0, 1);
        add(16'h0003, 16'h0005, 4'hA, 16'h0002, 16'h0000, 0, 0, 0, 1);
        add(16'h0064, 16'h0007, 4'h3, 16'h000E, 16'h0002, 0, 0, 0, 17);
        add(16'h1234, 16'h0000, 4'h3, 16'hFFFF, 16'h1234, 0, 0, 1, 1);
        add(16'h0007, 16'h0064, 4'hB, 16'h000E, 16'h0002, 0, 0, 0, 17);
        add(16'h0000, 16'h0005, 4'hB, 16'hFFFF, 16'h0005, 0, 0, 1, 1);
`ifdef ALU_ITER_MUL_EN
        add(16'h1234, 16'h0100, 4'h2, 16'h3400, 16'h0012, 0, 0, 0, 17);
`else
        add(16'h1234, 16'h0100, 4'h2, 16'h3400, 16'h0000, 0, 0, 0, 1);
`endif
        add(16'hF0F0, 16'hFF00, 4'h4, 16'hF000, 16'h0000, 0, 0, 0, 1);
        add(16'hF0F0, 16'hFF00, 4'h5, 16'hFFF0, 16'h0000, 0, 0, 0, 1);
        add(16'hF0F0, 16'hFF00, 4'h6, 16'h0FFF, 16'h0000, 0, 0, 0, 1);
        add(16'hF0F0, 16'hFF00, 4'h7, 16'h000F, 16'h0000, 0, 0, 0, 1);
        add(16'hF0F0, 16'hFF00, 4'h8, 16'h0F0F, 16'h0000, 0, 0, 0, 1);
        add(16'hF0F0, 16'hFF00, 4'h9, 16'h00FF, 16'h0000, 0, 0, 0, 1);
        add(16'hF0F0, 16'hFF00, 4'hC, 16'h000F, 16'h0000, 0, 0, 0, 1);
        add(16'hF0F0, 16'hFF00, 4'hD, 16'h0FFF, 16'h0000, 0, 0, 0, 1);
        add(16'hF0F0, 16'hFF00, 4'hE, 16'h00F0, 16'h0000, 0, 0, 0, 1);
        add(16'hF0F0, 16'hFF00, 4'hF, 16'h0F00, 16'h0000, 0, 0, 0, 1);
        add(16'h0005, 16'h0005, 4'h1, 16'h0000, 16'h0000, 0, 1, 0, 1);
        add(16'h8000, 16'h8000, 4'h0, 16'h0000, 16'h0000, 1, 1, 0, 1);
        add(16'h0004, 16'h0003, 4'h1, 16'h0001, 16'h0000, 0, 0, 0, 1);
        add(16'hFFFF, 16'h0001, 4'h3, 16'hFFFF, 16'h0000, 0, 0, 0, 17);
        add(16'h0003, 16'h0007, 4'h3, 16'h0000, 16'h0003, 0, 1, 0, 17);

        // Reset held two cycles with a valid request pending: nothing is accepted.
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
        a = 16'hFFFF; b = 16'h0001; sel = 4'h0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            chk($sformatf("rst%0d_out_valid", i), out_valid, 0);
            chk($sformatf("rst%0d_result", i), result, 0);
            chk($sformatf("rst%0d_rem", i), rem, 0);
            chk($sformatf("rst%0d_cout", i), cout, 0);
            chk($sformatf("rst%0d_zero", i), zero, 0);
            chk($sformatf("rst%0d_dbz", i), div_by_zero, 0);
        end
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_out_valid", out_valid, 0);

        for (int i = 0; i < vecs.size(); i++) do_op(vecs[i], i);

        // Back-pressure: result must hold while out_ready stays low, and a pending
        // request must not be taken.
        @(negedge clk);
        a = 16'h0064; b = 16'h0007; sel = 4'h3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (16) @(posedge clk);
        #1;
        chk("stall_out_valid_rise", out_valid, 1);
        a = 16'h1111; b = 16'h2222; sel = 4'h0; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk($sformatf("stall%0d_out_valid", i), out_valid, 1);
            chk($sformatf("stall%0d_result", i), result, 16'h000E);
            chk($sformatf("stall%0d_rem", i), rem, 16'h0002);
            chk($sformatf("stall%0d_in_ready", i), in_ready, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("stall_release_out_valid", out_valid, 0);
        chk("stall_release_in_ready", in_ready, 1);

        // Reset in the middle of a divide aborts it with no result.
        @(negedge clk);
        a = 16'h0064; b = 16'h0007; sel = 4'h3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("abort_busy_in_ready", in_ready, 0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_in_ready", in_ready, 1);
        chk("abort_result", result, 0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        chk("abort_no_output", seen, 0);

        // The block must still work normally after the abort.
        do_op(vecs[3], 100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Guard against a hung run.
    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
